fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles spent in T1 waiting on mem_ready before FAULT.
REQ-002 Parameter CNT_W, default 32: width of fetch_count.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 run  input  1  level; permits leaving IDLE and continuing fetch loop.
REQ-006 mem_ready  input  1  memory read data valid this cycle.
REQ-007 exec_done  input  1  one-cycle pulse from execute control; instruction finished.
REQ-008 halt  input  1  level; requests stop at next instruction boundary.
REQ-009 PCout  output  1  drive PC onto bus.
REQ-010 MARin  output  1  load MAR from bus.
REQ-011 PCenable  output  1  PC register load enable.
REQ-012 incPC  output  1  PC register loads bus+1 when PCenable is also high.
REQ-013 Read  output  1  memory read strobe.
REQ-014 MDRin  output  1  load MDR from memory data.
REQ-015 MDRout  output  1  drive MDR onto bus.
REQ-016 IRin  output  1  load instruction register from bus.
REQ-017 fetching  output  1  high in T0, T1, T2.
REQ-018 fault  output  1  high while in FAULT.
REQ-019 fetch_count  output  CNT_W  number of completed fetches (IRin pulses).

Function
REQ-020 States: IDLE, T0, T1, T2, EXEC, HALTED, FAULT; all outputs Moore-decoded from state (MDRin additionally qualified by mem_ready).
REQ-021 IDLE: all strobes low; run=1 and halt=0 -> T0 next cycle; otherwise stay.
REQ-022 T0 (exactly 1 cycle): PCout=1, MARin=1, PCenable=1, incPC=1; unconditionally -> T1.
REQ-023 T1: Read=1; MDRin=mem_ready; mem_ready=1 -> T2; otherwise wait counter increments.
REQ-024 Wait counter cleared on T1 entry; if it reaches MEM_TIMEOUT while mem_ready=0 -> FAULT; mem_ready=1 in the same cycle as the limit wins (-> T2).
REQ-025 T2 (exactly 1 cycle): MDRout=1, IRin=1; fetch_count increments by 1, wraps modulo 2^CNT_W; -> EXEC.
REQ-026 EXEC: all strobes low; waits for exec_done; exec_done=1: halt=1 -> HALTED, run=0 -> IDLE, else -> T0.
REQ-027 Minimum fetch latency: T0 to IRin = 3 cycles with mem_ready asserted in first T1 cycle; back-to-back instructions (exec_done asserted in first EXEC cycle) = 4 cycles per instruction.
REQ-028 halt and run sampled only in IDLE and at exec_done; changes mid-fetch do not abort T0-T2.
REQ-029 exec_done outside EXEC is ignored.
REQ-030 HALTED: all strobes low; exits only via clr.
REQ-031 FAULT: fault=1, all strobes low; exits only via clr.
REQ-032 At most one of PCout/MDRout high in any cycle (bus exclusivity).

Reset
REQ-033 clr=1 forces state IDLE, wait counter 0, fetch_count 0, all outputs 0, immediately without waiting for clk.
REQ-034 clr asserted mid-fetch (any state) aborts; no partial strobe persists after clr rises.
REQ-035 First fetch after clr deassertion requires run=1 sampled on a clk edge; T0 is never entered on the same edge clr falls.

Verification
REQ-036 clr pulse, then run=1, mem_ready=1 constant, exec_done pulsed in each EXEC cycle -> strobe sequence T0,T1,T2,EXEC repeats every 4 cycles; fetch_count=3 after third IRin.
REQ-037 mem_ready held 0 for 5 T1 cycles then 1 -> Read high 6 cycles, MDRin high only in 6th, IRin next cycle, fault=0.
REQ-038 mem_ready never asserted -> fault=1 after MEM_TIMEOUT (15) T1 cycles; all strobes 0; stays until clr.
REQ-039 halt=1 raised during T1 -> fetch completes (IRin pulses), HALTED entered on exec_done, no further T0.
REQ-040 clr asserted asynchronously between edges while in T1 -> Read, fetching drop before next edge; fetch_count=0.
REQ-041 fetch_count forced to wrap (CNT_W=4 build, 16 fetches) -> reads 0 after 16th IRin.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Handshake and datapath-strobe bundle between the fetch sequencer and the
// datapath / memory / execute control that it drives.
interface fetch_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             mem_ready;
  logic             exec_done;
  logic             halt;
  logic             PCout;
  logic             MARin;
  logic             PCenable;
  logic             incPC;
  logic             Read;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;
  logic             fetching;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  run, mem_ready, exec_done, halt,
    output PCout, MARin, PCenable, incPC, Read, MDRin, MDRout, IRin,
           fetching, fault, fetch_count
  );

  modport slave (
    output run, mem_ready, exec_done, halt,
    input  PCout, MARin, PCenable, incPC, Read, MDRin, MDRout, IRin,
           fetching, fault, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: T0 (PC->MAR, PC+1), T1 (memory read, bounded
// wait), T2 (MDR->IR), then hands off to execute until exec_done.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               clr,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, EXEC, HALTED, FAULT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic pc_enable;
    logic inc_pc;
    logic read;
    logic mdr_out;
    logic ir_in;
    logic fetching;
    logic fault;
  } strobes_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state;
  strobes_t           strobes;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   fetch_count;

  // Strobe pattern for each state; loaded together with the state so the
  // outputs come straight from flops.
  function automatic strobes_t decode(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      T0: begin
        o.pc_out    = 1'b1;
        o.mar_in    = 1'b1;
        o.pc_enable = 1'b1;
        o.inc_pc    = 1'b1;
        o.fetching  = 1'b1;
      end
      T1: begin
        o.read     = 1'b1;
        o.fetching = 1'b1;
      end
      T2: begin
        o.mdr_out  = 1'b1;
        o.ir_in    = 1'b1;
        o.fetching = 1'b1;
      end
      FAULT:   o.fault = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only; clr clears
  // every register asynchronously so no strobe outlives the reset edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      strobes     <= '0;
      wait_cnt    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.run && !bus.halt) begin
          state   <= T0;
          strobes <= decode(T0);
        end
        T0: begin
          state    <= T1;
          strobes  <= decode(T1);
          wait_cnt <= '0;
        end
        // Data arriving on the last allowed cycle still beats the timeout.
        T1: if (bus.mem_ready) begin
          state   <= T2;
          strobes <= decode(T2);
        end else if (wait_cnt == WAIT_LAST) begin
          state   <= FAULT;
          strobes <= decode(FAULT);
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        T2: begin
          state       <= EXEC;
          strobes     <= decode(EXEC);
          fetch_count <= fetch_count + 1'b1;
        end
        EXEC: if (bus.exec_done) begin
          if (bus.halt) begin
            state   <= HALTED;
            strobes <= decode(HALTED);
          end else if (!bus.run) begin
            state   <= IDLE;
            strobes <= decode(IDLE);
          end else begin
            state   <= T0;
            strobes <= decode(T0);
          end
        end
        default: ;  // HALTED and FAULT are left only through clr
      endcase
    end
  end

  assign bus.PCout       = strobes.pc_out;
  assign bus.MARin       = strobes.mar_in;
  assign bus.PCenable    = strobes.pc_enable;
  assign bus.incPC       = strobes.inc_pc;
  assign bus.Read        = strobes.read;
  assign bus.MDRin       = strobes.read & bus.mem_ready;
  assign bus.MDRout      = strobes.mdr_out;
  assign bus.IRin        = strobes.ir_in;
  assign bus.fetching    = strobes.fetching;
  assign bus.fault       = strobes.fault;
  assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default build for sequencing, wait,
// timeout, halt and reset behaviour; a CNT_W=4 build for counter wrap.
module tb_fetch_sequencer;

  logic clk;
  logic clr;

  fetch_sequencer_if               b  ();
  fetch_sequencer_if #(.CNT_W(4))  b4 ();

  fetch_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (b)
  );

  fetch_sequencer #(.CNT_W(4)) dut4 (
    .clk (clk),
    .clr (clr),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCout,MARin,PCenable,incPC,Read,MDRin,MDRout,IRin,fetching,fault}
  localparam logic [9:0] S_IDLE = 10'b0000000000;
  localparam logic [9:0] S_T0   = 10'b1111000010;
  localparam logic [9:0] S_T1W  = 10'b0000100010;
  localparam logic [9:0] S_T1R  = 10'b0000110010;
  localparam logic [9:0] S_T2   = 10'b0000001110;
  localparam logic [9:0] S_FLT  = 10'b0000000001;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [9:0] sv();
    return {b.PCout, b.MARin, b.PCenable, b.incPC, b.Read, b.MDRin,
            b.MDRout, b.IRin, b.fetching, b.fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr          = 1'b1;
    b.run        = 1'b0;
    b.mem_ready  = 1'b0;
    b.exec_done  = 1'b0;
    b.halt       = 1'b0;
    b4.run       = 1'b0;
    b4.mem_ready = 1'b0;
    b4.exec_done = 1'b0;
    b4.halt      = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("reset_strobes", 32'(sv()), 32'(S_IDLE));
    check("reset_count", b.fetch_count, 32'd0);

    // Back-to-back fetches, mem_ready and exec_done held high
    b.run       = 1'b1;
    b.mem_ready = 1'b1;
    b.exec_done = 1'b1;
    clr         = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc(); check("b2b_t0", 32'(sv()), 32'(S_T0));
      cyc(); check("b2b_t1", 32'(sv()), 32'(S_T1R));
      cyc(); check("b2b_t2", 32'(sv()), 32'(S_T2));
      check("b2b_cnt_t2", b.fetch_count, 32'(i - 1));
      cyc(); check("b2b_exec", 32'(sv()), 32'(S_IDLE));
      check("b2b_cnt", b.fetch_count, 32'(i));
      if (i == 3) b.run = 1'b0;
    end
    cyc(); check("idle_after_run0", 32'(sv()), 32'(S_IDLE));
    cyc(); check("idle_stays", 32'(sv()), 32'(S_IDLE));

    // Five wait cycles in T1, data on the sixth
    b.mem_ready = 1'b0;
    b.exec_done = 1'b0;
    b.run       = 1'b1;
    cyc(); check("wait_t0", 32'(sv()), 32'(S_T0));
    for (int k = 0; k < 5; k++) begin
      cyc(); check("wait_t1", 32'(sv()), 32'(S_T1W));
    end
    cyc();
    b.mem_ready = 1'b1;
    #1;
    check("wait_t1_ready", 32'(sv()), 32'(S_T1R));
    cyc(); check("wait_t2", 32'(sv()), 32'(S_T2));
    cyc(); check("wait_exec", 32'(sv()), 32'(S_IDLE));
    check("wait_cnt", b.fetch_count, 32'd4);
    b.run       = 1'b0;
    b.exec_done = 1'b1;
    cyc(); check("wait_idle", 32'(sv()), 32'(S_IDLE));
    b.exec_done = 1'b0;

    // Memory never responds: FAULT after 15 T1 cycles, sticky until clr
    b.mem_ready = 1'b0;
    b.run       = 1'b1;
    cyc(); check("to_t0", 32'(sv()), 32'(S_T0));
    for (int k = 0; k < 15; k++) begin
      cyc(); check("to_t1", 32'(sv()), 32'(S_T1W));
    end
    cyc(); check("to_fault", 32'(sv()), 32'(S_FLT));
    b.mem_ready = 1'b1;
    b.exec_done = 1'b1;
    cyc();
    cyc(); check("to_fault_hold", 32'(sv()), 32'(S_FLT));
    check("to_cnt", b.fetch_count, 32'd4);
    clr = 1'b1;
    #2;
    check("clr_async_strobes", 32'(sv()), 32'(S_IDLE));
    check("clr_async_cnt", b.fetch_count, 32'd0);
    cyc();
    b.mem_ready = 1'b0;
    b.exec_done = 1'b0;
    clr         = 1'b0;

    // Data arriving in the 15th T1 cycle wins over the timeout
    cyc(); check("lim_t0", 32'(sv()), 32'(S_T0));
    for (int k = 0; k < 14; k++) begin
      cyc(); check("lim_t1", 32'(sv()), 32'(S_T1W));
    end
    cyc();
    b.mem_ready = 1'b1;
    #1;
    check("lim_t1_ready", 32'(sv()), 32'(S_T1R));
    cyc(); check("lim_t2", 32'(sv()), 32'(S_T2));
    cyc(); check("lim_exec", 32'(sv()), 32'(S_IDLE));
    check("lim_cnt", b.fetch_count, 32'd1);

    // halt raised mid-fetch: fetch completes, then HALTED on exec_done
    b.exec_done = 1'b1;
    cyc(); check("halt_t0", 32'(sv()), 32'(S_T0));
    b.exec_done = 1'b0;
    cyc(); check("halt_t1", 32'(sv()), 32'(S_T1R));
    b.halt = 1'b1;
    cyc(); check("halt_t2", 32'(sv()), 32'(S_T2));
    cyc(); check("halt_exec", 32'(sv()), 32'(S_IDLE));
    check("halt_cnt", b.fetch_count, 32'd2);
    b.exec_done = 1'b1;
    cyc(); check("halted", 32'(sv()), 32'(S_IDLE));
    b.exec_done = 1'b0;
    b.halt      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); check("halted_hold", 32'(sv()), 32'(S_IDLE));
    end
    check("halted_cnt", b.fetch_count, 32'd2);

    // clr between edges while in T1
    clr = 1'b1;
    cyc();
    clr         = 1'b0;
    b.mem_ready = 1'b0;
    cyc(); check("abort_t0", 32'(sv()), 32'(S_T0));
    cyc(); check("abort_t1", 32'(sv()), 32'(S_T1W));
    #3;
    clr = 1'b1;
    #1;
    check("abort_strobes", 32'(sv()), 32'(S_IDLE));
    check("abort_cnt", b.fetch_count, 32'd0);
    cyc();
    clr   = 1'b0;
    b.run = 1'b0;

    // CNT_W=4 build: 16 fetches wrap the counter to 0
    b4.run       = 1'b1;
    b4.mem_ready = 1'b1;
    b4.exec_done = 1'b1;
    cyc();
    check("wrap_t0", 32'(b4.PCout), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      cyc(); check("wrap_irin", 32'(b4.IRin), 32'd1);
      cyc(); check("wrap_cnt", 32'(b4.fetch_count), 32'(i % 16));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
